// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller for a 16-bit asynchronous SRAM: each 32-bit load/store
// becomes two half-word phases of SRAM_WAIT cycles, with ready low meanwhile.
module sram_mem_ctrl #(
    parameter int unsigned ADDR_BASE = 1024,
    parameter int unsigned SRAM_WAIT = 5,
    parameter int unsigned SRAM_AW   = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read_enable,
    input  logic               mem_write_enable,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int unsigned CW  = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam int unsigned WAW = SRAM_AW - 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [WAW-1:0]  word_q;
    logic [31:0]     wdata_q;
    logic            write_q;
    logic [WAW-1:0]  word_idx;
    logic            req;

    // Wrapping subtraction; bits above the SRAM word range are simply dropped.
    assign word_idx = WAW'((address - ADDR_BASE) >> 2);
    assign req      = mem_read_enable | mem_write_enable;
    assign ready    = (state == DONE) | ((state == IDLE) & ~req);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            word_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            read_data <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && req) begin
                word_q  <= word_idx;
                wdata_q <= write_data;
                write_q <= mem_write_enable;
            end
            // Sample the SRAM at the end of each read phase, after the full wait.
            if (!write_q && cnt == '0) begin
                if (state == LOW)
                    read_data[15:0] <= sram_dq_in;
                else if (state == HIGH)
                    read_data[31:16] <= sram_dq_in;
            end
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = LOW;
                    cnt_next   = CW'(SRAM_WAIT - 1);
                end
            end
            LOW: begin
                sram_addr = {word_q, 1'b0};
                if (write_q) begin
                    sram_dq_out = wdata_q[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
                if (cnt == '0) begin
                    state_next = HIGH;
                    cnt_next   = CW'(SRAM_WAIT - 1);
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            HIGH: begin
                sram_addr = {word_q, 1'b1};
                if (write_q) begin
                    sram_dq_out = wdata_q[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
                if (cnt == '0) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: directed scenarios plus random
// loads/stores against a word-level reference memory and a 16-bit SRAM model.
module tb_sram_mem_ctrl;

    localparam int unsigned BASE = 1024;
    localparam int unsigned W    = 5;
    localparam int unsigned AW   = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          mre, mwe;
    logic [31:0]   address, write_data, read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out, sram_dq_in;
    logic          sram_dq_oe, sram_we_n;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_rd;
    logic [31:0] ref_words [int unsigned];
    logic [15:0] sram [0:(1<<AW)-1];

    sram_mem_ctrl #(.ADDR_BASE(BASE), .SRAM_WAIT(W), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .mem_read_enable(mre), .mem_write_enable(mwe),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    assign sram_dq_in = sram[sram_addr];
    always @(posedge clk)
        if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return ((a - BASE) >> 2) & ((1 << (AW - 1)) - 1);
    endfunction

    // Cycle 0 = request cycle; phases 1..2W; DONE at 2W+1.
    task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        int unsigned w;
        logic [31:0] exp_addr, exp_dq;
        bit hi;
        w = widx(a);
        @(negedge clk);
        mwe = wr; mre = rd; address = a; write_data = d;
        #1;
        check("req_ready", {31'b0, ready}, 32'd0);
        for (int c = 1; c <= 2 * W; c++) begin
            hi = (c > W);
            @(negedge clk); #1;
            exp_addr = (w << 1) | (hi ? 32'd1 : 32'd0);
            exp_dq   = wr ? (hi ? {16'b0, d[31:16]} : {16'b0, d[15:0]}) : 32'd0;
            check("busy_ready", {31'b0, ready}, 32'd0);
            check("phase_addr", {14'b0, sram_addr}, exp_addr);
            check("phase_we_n", {31'b0, sram_we_n}, wr ? 32'd0 : 32'd1);
            check("phase_oe", {31'b0, sram_dq_oe}, wr ? 32'd1 : 32'd0);
            check("phase_dq", {16'b0, sram_dq_out}, exp_dq);
        end
        if (wr) ref_words[w] = d;
        else    exp_rd = ref_words[w];
        @(negedge clk);
        if (!hold) begin mwe = 1'b0; mre = 1'b0; end
        #1;
        check("done_ready", {31'b0, ready}, 32'd1);
        check("done_we_n", {31'b0, sram_we_n}, 32'd1);
        check("done_oe", {31'b0, sram_dq_oe}, 32'd0);
        check("done_addr", {14'b0, sram_addr}, 32'd0);
        check("read_data", read_data, exp_rd);
    endtask

    initial begin
        int unsigned w;
        logic [31:0] a, d;
        bit wr;
        rst = 1'b1; mre = 1'b0; mwe = 1'b0; address = '0; write_data = '0;
        exp_rd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_addr", {14'b0, sram_addr}, 32'd0);
        check("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        check("rst_oe", {31'b0, sram_dq_oe}, 32'd0);
        check("rst_rdata", read_data, 32'd0);

        access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        check("load_deadbeef", read_data, 32'hDEADBEEF);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            check("idle_ready", {31'b0, ready}, 32'd1);
            check("idle_addr", {14'b0, sram_addr}, 32'd0);
            check("idle_we_n", {31'b0, sram_we_n}, 32'd1);
            check("idle_rdata", read_data, 32'hDEADBEEF);
        end

        // Both enables: the write takes priority and read_data must not move.
        access(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
        check("both_rdata", read_data, 32'hDEADBEEF);

        // Reset in cycle 4 of a store leaves only the low half written.
        @(negedge clk);
        mwe = 1'b1; address = 32'd1028; write_data = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; mwe = 1'b0;
        #1;
        check("mid_rst_we_n", {31'b0, sram_we_n}, 32'd1);
        check("mid_rst_oe", {31'b0, sram_dq_oe}, 32'd0);
        check("mid_rst_rdata", read_data, 32'd0);
        check("mid_rst_ready", {31'b0, ready}, 32'd1);
        exp_rd = '0;
        ref_words[widx(32'd1028)] = 32'hDEADF00D;
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);

        // Back-to-back loads with the request held through DONE.
        access(1'b1, 1'b0, 32'd1032, 32'hA5A55A5A, 1'b0);
        access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
        access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
        check("b2b_rdata", read_data, 32'hA5A55A5A);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                a = BASE - 4 * $urandom_range(1, 8);
            else
                a = BASE + 4 * $urandom_range(0, 15);
            a = a | $urandom_range(0, 3);
            d = $urandom;
            w = widx(a);
            wr = ($urandom_range(0, 1) == 1) || !ref_words.exists(w);
            access(wr, !wr || ($urandom_range(0, 1) == 1), a, d, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
